// File: rtl/psram_arb.sv
// rtl/psram_arb.sv - two-requester round-robin PSRAM arbiter that splits requests into page-safe bursts
module psram_arb #(
    parameter int MAX_BURST  = 16,
    parameter int PAGE_BYTES = 1024
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [1:0]       req_valid_i,
    output logic [1:0]       req_ready_o,
    input  logic [1:0]       req_we_i,
    input  logic [1:0][31:0] req_addr_i,
    input  logic [1:0][7:0]  req_len_i,
    output logic [1:0]       req_done_o,
    output logic [1:0]       req_err_o,
    output logic [1:0]       grant_o,
    output logic             core_valid_o,
    output logic             core_we_o,
    output logic [31:0]      core_addr_o,
    output logic [7:0]       core_len_o,
    input  logic             core_ready_i,
    input  logic             core_done_i
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_DONE} state_t;

    localparam logic [31:0] PAGE_B    = 32'(PAGE_BYTES);
    localparam logic [31:0] PAGE_MASK = 32'(PAGE_BYTES - 1);
    localparam logic [7:0]  MAX_B     = 8'(MAX_BURST);

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  rem_q, rem_d;
    logic [1:0]  err_q, err_d;

    logic        sel;
    logic [1:0]  sel_oh, own_oh;
    logic        bad;
    logic [31:0] page_left;
    logic [7:0]  chunk;

    // Tie goes to whoever was not served last; a lone requester always wins.
    always_comb begin
        sel = (req_valid_i == 2'b11) ? ~last_q : req_valid_i[1];
    end

    assign sel_oh = sel ? 2'b10 : 2'b01;
    assign own_oh = owner_q ? 2'b10 : 2'b01;
    assign bad    = req_addr_i[sel][0] || (req_len_i[sel] == 8'd0) ||
                    (req_we_i[sel] && req_len_i[sel][0]);

    always_comb begin
        page_left = PAGE_B - (addr_q & PAGE_MASK);
        chunk     = rem_q;
        if (MAX_B < chunk) begin
            chunk = MAX_B;
        end
        if (page_left < {24'd0, chunk}) begin
            chunk = page_left[7:0];
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_d       = last_q;
        we_d         = we_q;
        addr_d       = addr_q;
        rem_d        = rem_q;
        err_d        = 2'b00;
        req_ready_o  = 2'b00;
        req_done_o   = 2'b00;
        grant_o      = 2'b00;
        core_valid_o = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (rst_n_i && (req_valid_i != 2'b00)) begin
                    req_ready_o = sel_oh;
                    grant_o     = sel_oh;
                    if (bad) begin
                        err_d  = sel_oh;
                        last_d = sel;
                    end else begin
                        owner_d = sel;
                        we_d    = req_we_i[sel];
                        addr_d  = req_addr_i[sel];
                        rem_d   = req_len_i[sel];
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                grant_o      = own_oh;
                core_valid_o = 1'b1;
                if (core_ready_i) begin
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                grant_o = own_oh;
                if (core_done_i) begin
                    addr_d  = addr_q + {24'd0, chunk};
                    rem_d   = rem_q - chunk;
                    state_d = (rem_q == chunk) ? S_DONE : S_ISSUE;
                end
            end
            S_DONE: begin
                grant_o    = own_oh;
                req_done_o = own_oh;
                last_d     = owner_q;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign req_err_o   = err_q;
    assign core_we_o   = core_valid_o & we_q;
    assign core_addr_o = core_valid_o ? addr_q : 32'd0;
    assign core_len_o  = core_valid_o ? chunk : 8'd0;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            rem_q   <= 8'd0;
            err_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_psram_arb.sv
// tb/tb_psram_arb.sv - directed scoreboard bench for psram_arb
module tb_psram_arb;
    logic             clk_i = 1'b0;
    logic             rst_n_i;
    logic [1:0]       req_valid_i;
    logic [1:0]       req_ready_o;
    logic [1:0]       req_we_i;
    logic [1:0][31:0] req_addr_i;
    logic [1:0][7:0]  req_len_i;
    logic [1:0]       req_done_o;
    logic [1:0]       req_err_o;
    logic [1:0]       grant_o;
    logic             core_valid_o;
    logic             core_we_o;
    logic [31:0]      core_addr_o;
    logic [7:0]       core_len_o;
    logic             core_ready_i;
    logic             core_done_i;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic        we;
    } chunk_t;

    chunk_t sb[$];
    int     n_pass  = 0;
    int     n_total = 0;

    psram_arb #(.MAX_BURST(16), .PAGE_BYTES(1024)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_we_i(req_we_i), .req_addr_i(req_addr_i), .req_len_i(req_len_i),
        .req_done_o(req_done_o), .req_err_o(req_err_o), .grant_o(grant_o),
        .core_valid_o(core_valid_o), .core_we_o(core_we_o),
        .core_addr_o(core_addr_o), .core_len_o(core_len_o),
        .core_ready_i(core_ready_i), .core_done_i(core_done_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({req_ready_o, req_done_o, req_err_o, grant_o,
                    core_valid_o, core_we_o, core_addr_o, core_len_o});
    endfunction

    // Reference chunking: min(remaining, 16, bytes left in the 1 KiB page).
    task automatic push_chunks(input logic we, input logic [31:0] a, input int len);
        int          rem;
        int          c;
        int          left;
        logic [31:0] addr;
        chunk_t      e;
        rem  = len;
        addr = a;
        while (rem > 0) begin
            left = 1024 - int'(addr % 1024);
            c    = rem;
            if (c > 16) c = 16;
            if (c > left) c = left;
            e.addr = addr;
            e.len  = 8'(c);
            e.we   = we;
            sb.push_back(e);
            addr = addr + 32'(c);
            rem  = rem - c;
        end
    endtask

    task automatic set_req(input int r, input logic we, input logic [31:0] a, input logic [7:0] l);
        req_valid_i[r] = 1'b1;
        req_we_i[r]    = we;
        req_addr_i[r]  = a;
        req_len_i[r]   = l;
    endtask

    task automatic serve(input int r, input int dly);
        int     n;
        chunk_t e;
        while (sb.size() > 0) begin
            n = 0;
            while (!core_valid_o && n < 20) begin
                tick();
                n++;
            end
            check("cmd_latency", 64'(n), 64'd0);
            check("core_valid", 64'(core_valid_o), 64'd1);
            e = sb.pop_front();
            check("core_addr", 64'(core_addr_o), 64'(e.addr));
            check("core_len", 64'(core_len_o), 64'(e.len));
            check("core_we", 64'(core_we_o), 64'(e.we));
            for (int k = 0; k < dly; k++) begin
                if (k == 0) core_done_i = 1'b1;
                tick();
                core_done_i = 1'b0;
                #1;
                check("hold_valid", 64'(core_valid_o), 64'd1);
                check("hold_addr", 64'(core_addr_o), 64'(e.addr));
                check("hold_len", 64'(core_len_o), 64'(e.len));
            end
            core_ready_i = 1'b1;
            tick();
            core_ready_i = 1'b0;
            #1;
            check("busy_no_valid", 64'(core_valid_o), 64'd0);
            check("busy_grant", 64'(grant_o), 64'(2'b01 << r));
            tick();
            core_done_i = 1'b1;
            tick();
            core_done_i = 1'b0;
            #1;
        end
        n = 0;
        while (req_done_o == 2'b00 && n < 20) begin
            tick();
            n++;
        end
        check("done_pulse", 64'(req_done_o), 64'(2'b01 << r));
        check("done_grant", 64'(grant_o), 64'(2'b01 << r));
        tick();
        #1;
        check("done_single", 64'(req_done_o), 64'd0);
    endtask

    initial begin
        rst_n_i      = 1'b0;
        req_valid_i  = 2'b00;
        req_we_i     = 2'b00;
        req_addr_i   = '0;
        req_len_i    = '0;
        core_ready_i = 1'b0;
        core_done_i  = 1'b0;
        set_req(0, 1'b0, 32'h10, 8'd4);
        set_req(1, 1'b1, 32'h20, 8'd8);
        tick();
        tick();
        #1;
        check("reset_outs", all_outs(), 64'd0);

        // Both valid out of reset: requester 0 first, requester 1 right after its DONE.
        rst_n_i = 1'b1;
        #1;
        check("rr_first_ready", 64'(req_ready_o), 64'h1);
        check("rr_first_grant", 64'(grant_o), 64'h1);
        push_chunks(1'b0, 32'h10, 4);
        tick();
        req_valid_i[0] = 1'b0;
        serve(0, 0);
        check("rr_second_ready", 64'(req_ready_o), 64'h2);
        push_chunks(1'b1, 32'h20, 8);
        tick();
        req_valid_i[1] = 1'b0;
        serve(1, 0);
        check("idle_grant", 64'(grant_o), 64'd0);

        // Page-crossing read: expect (0x3F8,8) (0x400,16) (0x410,16).
        set_req(0, 1'b0, 32'h3F8, 8'd40);
        #1;
        check("page_ready", 64'(req_ready_o), 64'h1);
        push_chunks(1'b0, 32'h3F8, 40);
        check("page_nchunks", 64'(sb.size()), 64'd3);
        tick();
        req_valid_i[0] = 1'b0;
        serve(0, 0);

        // Rejections: odd-length write, then odd-address read.
        set_req(1, 1'b1, 32'h300, 8'd3);
        #1;
        check("rej1_ready", 64'(req_ready_o), 64'h2);
        tick();
        req_valid_i[1] = 1'b0;
        #1;
        check("rej1_err", 64'(req_err_o), 64'h2);
        check("rej1_no_cmd", 64'(core_valid_o), 64'd0);
        tick();
        #1;
        check("rej1_err_single", 64'(req_err_o), 64'd0);
        set_req(0, 1'b0, 32'h101, 8'd4);
        #1;
        check("rej2_ready", 64'(req_ready_o), 64'h1);
        tick();
        req_valid_i[0] = 1'b0;
        #1;
        check("rej2_err", 64'(req_err_o), 64'h1);
        check("rej2_no_cmd", 64'(core_valid_o), 64'd0);
        tick();

        // Pointer now points at requester 0, so a tie goes to 1; core stalls 5 cycles.
        set_req(1, 1'b0, 32'h200, 8'd16);
        set_req(0, 1'b0, 32'h0, 8'd2);
        #1;
        check("rr_after_rej", 64'(req_ready_o), 64'h2);
        push_chunks(1'b0, 32'h200, 16);
        tick();
        req_valid_i[1] = 1'b0;
        serve(1, 5);
        check("rr_next_ready", 64'(req_ready_o), 64'h1);
        push_chunks(1'b0, 32'h0, 2);
        tick();
        req_valid_i[0] = 1'b0;
        serve(0, 0);

        // 32-bit address wrap.
        set_req(0, 1'b1, 32'hFFFF_FFF8, 8'd16);
        #1;
        check("wrap_ready", 64'(req_ready_o), 64'h1);
        push_chunks(1'b1, 32'hFFFF_FFF8, 16);
        tick();
        req_valid_i[0] = 1'b0;
        serve(0, 0);

        // Reset during BUSY abandons the request.
        set_req(0, 1'b0, 32'h40, 8'd32);
        #1;
        check("rst_req_ready", 64'(req_ready_o), 64'h1);
        tick();
        req_valid_i[0] = 1'b0;
        #1;
        check("rst_req_cmd", 64'(core_valid_o), 64'd1);
        core_ready_i = 1'b1;
        tick();
        core_ready_i = 1'b0;
        rst_n_i = 1'b0;
        tick();
        #1;
        check("midrst_outs", all_outs(), 64'd0);
        rst_n_i = 1'b1;
        sb.delete();
        tick();
        #1;
        check("midrst_no_done", 64'({req_done_o, req_err_o}), 64'd0);
        set_req(1, 1'b0, 32'h80, 8'd2);
        #1;
        check("post_rst_ready", 64'(req_ready_o), 64'h2);
        push_chunks(1'b0, 32'h80, 2);
        tick();
        req_valid_i[1] = 1'b0;
        serve(1, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/psram_arb.md
PSRAM_ARB -- requirements
Module: psram_arb

Interface
REQ-001 SHALL have parameter MAX_BURST, default 16, meaning the maximum bytes per CE-low core transaction (even, at least 2).
REQ-002 SHALL have parameter PAGE_BYTES, default 1024, meaning the PSRAM page size (power of two, at least MAX_BURST); no core transaction may cross a page boundary.
REQ-003 SHALL have port clk_i, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n_i, input, 1 bit: reset is synchronous and active-low.
REQ-005 SHALL have port req_valid_i, input, 2 bits: per-requester request valid (index 0 = config-register path, index 1 = memory bus).
REQ-006 SHALL have port req_ready_o, output, 2 bits: per-requester accept strobe, one-hot, at most one cycle per request.
REQ-007 SHALL have ports req_we_i (2x1), req_addr_i (2x32) and req_len_i (2x8), inputs: per-requester write flag, start byte address and byte length.
REQ-008 SHALL have ports req_done_o and req_err_o, outputs, 2 bits each: per-requester single-cycle completion and rejection pulses.
REQ-009 SHALL have port grant_o, output, 2 bits: one-hot owner of the core, used to steer the data mux; 0 when idle.
REQ-010 SHALL have ports core_valid_o (1), core_we_o (1), core_addr_o (32) and core_len_o (8), outputs: chunk command to the PSRAM core.
REQ-011 SHALL have ports core_ready_i (1) and core_done_i (1), inputs: command accept, and end of the core's RECY phase.

Function
REQ-012 SHALL implement FSM states IDLE, ISSUE, BUSY and DONE.
REQ-013 In IDLE with any req_valid_i set, SHALL select one requester by round-robin, assert its req_ready_o for one cycle, and latch its we, addr and len.
REQ-014 Round-robin: on a tie the requester not granted last wins; the last-granted pointer updates only on DONE or on a rejection.
REQ-015 SHALL reject at accept, pulsing req_err_o on the next cycle and returning to IDLE with no core activity, when: addr[0]=1, len=0, or a write has odd len.
REQ-016 After a valid accept, SHALL enter ISSUE on the next cycle with core_valid_o=1 (accept-to-command latency = 1 cycle).
REQ-017 Chunk length SHALL be min(remaining, MAX_BURST, PAGE_BYTES - (addr mod PAGE_BYTES)); core_addr_o is the current address.
REQ-018 core_valid_o and the command fields SHALL be held stable until core_ready_i; the handshake cycle moves the FSM to BUSY.
REQ-019 In BUSY, on core_done_i, SHALL advance addr by the chunk length and reduce remaining by the chunk length; if remaining>0, go to ISSUE on the next cycle, else go to DONE.
REQ-020 DONE SHALL pulse req_done_o for the owner for one cycle, clear grant_o, and return to IDLE; a new accept is possible on the following cycle.
REQ-021 grant_o SHALL be set from the accept cycle through DONE inclusive, and SHALL be unchanged for the whole request.
REQ-022 A core_done_i outside BUSY SHALL be ignored; a deasserted req_valid_i after accept SHALL not affect the request in flight.
REQ-023 Address arithmetic SHALL be 32-bit and wrap at 2^32 without error.

Reset
REQ-024 On rst_n_i=0 at a clock edge: FSM returns to IDLE; all outputs are 0; the round-robin pointer is set to 1 so that requester 0 wins the first tie.
REQ-025 Reset mid-operation SHALL abandon the request with no done or err pulse; the core shares the same reset.

Verification
REQ-026 Both requesters valid after reset -> requester 0 is accepted first; requester 1 is accepted in the cycle after requester 0's DONE.
REQ-027 Read, addr=0x3F8, len=40, MAX_BURST=16 -> chunks (0x3F8,8), (0x400,16), (0x410,16), then one req_done_o pulse.
REQ-028 Write with len=3, or read with addr=0x101 -> req_err_o pulse, no core_valid_o, pointer advances.
REQ-029 core_ready_i held low for 5 cycles -> core_valid_o, addr and len stay stable; exactly one chunk is issued.
REQ-030 rst_n_i low during BUSY -> next cycle in IDLE with all outputs 0; a following request proceeds normally.
